apb_i2c_regfile: RTL
====================

// Module: apb_i2c_regfile
// PURPOSE
//  Parametrised APB3 register file and host interface for the I2C controller.
//  Sits between the APB bus and the I2C core and TX/RX FIFOs.
//  Adds byte strobes, PSLVERR, wait states on RX-FIFO reads, and a maskable,
//  write-1-to-clear interrupt block.
// PARAMETERS
//  DATA_WIDTH   32  APB data width; legal values 8/16/32; registers occupy byte lane 0
//  ADDR_WIDTH   8   APB address width; decode uses paddr_i[7:0], upper bits must be 0
//  FIFO_RD_LAT  1   cycles from rx_pop_o to valid rx_data_i; legal 0..3
//  N_IRQ        4   number of interrupt event sources; legal 1..8
// PORTS
//  pclk_i               in   1             clock
//  preset_ni            in   1             asynchronous reset, active-low
//  paddr_i              in   ADDR_WIDTH    register address
//  psel_i/penable_i     in   1             APB select / access phase
//  pwrite_i             in   1             1 = write, 0 = read
//  pwdata_i             in   DATA_WIDTH    write data
//  pstrb_i              in   DATA_WIDTH/8  write byte strobes
//  prdata_o             out  DATA_WIDTH    read data; upper bytes always 0
//  pready_o             out  1             transfer complete
//  pslverr_o            out  1             error; valid only when pready_o=1
//  tx_full_i            in   1             TX-FIFO full
//  tx_push_o            out  1             1-cycle pulse, write tx_data_o into TX-FIFO
//  tx_data_o            out  8             TX byte
//  rx_empty_i           in   1             RX-FIFO empty
//  rx_pop_o             out  1             1-cycle pulse, pop RX-FIFO
//  rx_data_i            in   8             RX byte, valid FIFO_RD_LAT cycles after pop
//  status_i             in   8             core/FIFO status, read-only
//  start_done_i         in   1             core accepted START; clears CMD[6]
//  reset_done_i         in   1             core finished reset; sets CMD[7]
//  event_i              in   N_IRQ         interrupt event pulses
//  reg_slave_address_o  out  8             SADDR register
//  reg_command_o        out  8             CMD register
//  reg_prescale_o       out  8             PRESCALE register
//  irq_o                out  1             |(IRQ_STAT & IRQ_EN), registered
// BEHAVIOUR
//  Reset: every output and register is 0; FSM is in IDLE. An async reset during
//   a transfer aborts it, with no push or pop afterwards.
//  Register map:
//   0x00  TX        W: push byte      R: last written byte
//   0x04  RX        R: pop byte
//   0x08  STATUS    RO, status_i
//   0x0C  SADDR     RW
//   0x10  CMD       RW bits [7:5]; other bits read 0
//   0x14  PRESCALE  RW
//   0x18  IRQ_STAT  W1C
//   0x1C  IRQ_EN    RW, bits [N_IRQ-1:0]
//  FSM states:
//   IDLE   -> SETUP when psel_i & ~penable_i
//   SETUP  -> ACCESS
//   ACCESS -> IDLE, or -> RXWAIT for an RX read with FIFO_RD_LAT > 0
//   RXWAIT -> IDLE once the counter reaches FIFO_RD_LAT
//   psel_i low in RXWAIT (protocol error) -> IDLE; the popped byte is discarded.
//  Zero-wait accesses: every access except RX completes in its first ACCESS cycle,
//   pready_o=1, with prdata_o driven combinationally from the selected register.
//  RX read:
//   - rx_pop_o pulses in the first ACCESS cycle.
//   - pready_o stays 0 for FIFO_RD_LAT cycles, then is 1 with prdata_o = rx_data_i.
//   - rx_empty_i=1 at ACCESS: no pop, zero-wait, pslverr_o=1, prdata_o=0.
//  TX write:
//   - Update when pstrb_i[0]=1: tx_data_o updates and tx_push_o pulses the next cycle.
//   - tx_full_i=1: no push, pslverr_o=1, tx_data_o unchanged.
//  Byte strobes: pstrb_i[0]=0 on any write means no register update and no error.
//  Error cases, each completing zero-wait with pslverr_o=1:
//   - unmapped address; reads return 0
//   - write to STATUS or RX
//   - read of TX is NOT an error
//  Hardware updates to CMD:
//   - reset_done_i sets CMD[7]; start_done_i clears CMD[6].
//   - An APB write to CMD in the same cycle takes precedence.
//  IRQ_STAT[i] set by event_i[i]:
//   - Setting wins over a simultaneous W1C of the same bit.
//   - irq_o updates one cycle after any STAT/EN change.
// STRUCTURE
//  Package i2c_regmap_pkg:
//   - address localparams (ADDR_TX .. ADDR_IRQ_EN)
//   - CMD bit indices (CMD_RST=7, CMD_START=6, CMD_RW=5)
//   - FSM state encoding (2-bit: IDLE, SETUP, ACCESS, RXWAIT)
//  Sub-module i2c_irq_ctrl (#N_IRQ): STAT/EN flops, W1C/set priority, irq_o register.
// TESTING
//  1. Write 0x0C=0xA5 then read 0x0C, zero wait
//     -> prdata_o=0xA5, pslverr_o=0, pready_o high in the 1st ACCESS cycle.
//  2. FIFO_RD_LAT=2, rx_empty_i=0, rx_data_i=0x3C, read 0x04
//     -> one rx_pop_o pulse, 2 wait cycles, prdata_o=0x3C.
//     Repeat with rx_empty_i=1 -> no pop, pslverr_o=1.
//  3. Write 0x00=0x55 with tx_full_i=0 -> tx_push_o 1 cycle, tx_data_o=0x55.
//     Repeat with tx_full_i=1 -> no push, pslverr_o=1.
//     Repeat with pstrb_i=0 -> nothing changes, no error.
//  4. IRQ_EN=0x1, event_i[0] pulse -> irq_o=1 next cycle.
//     W1C 0x18=0x1 in the same cycle as a new event_i[0] -> bit stays 1.
//     W1C alone -> irq_o=0.
//  5. Write CMD=0x40, then pulse start_done_i -> CMD reads 0x00.
//     reset_done_i coincident with a write of CMD=0x20 -> CMD=0x20.
//  6. Assert preset_ni low during RXWAIT
//     -> all outputs 0; the next read of 0x0C returns 0x00, with no stray pop.

Source files
------------

// File: rtl/i2c_regmap_pkg.sv
`default_nettype none
// i2c_regmap_pkg: register map, CMD bit positions and APB FSM encoding for the
// I2C host interface (rev 1.0).
package i2c_regmap_pkg;

  localparam logic [7:0] ADDR_TX       = 8'h00;
  localparam logic [7:0] ADDR_RX       = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h08;
  localparam logic [7:0] ADDR_SADDR    = 8'h0C;
  localparam logic [7:0] ADDR_CMD      = 8'h10;
  localparam logic [7:0] ADDR_PRESCALE = 8'h14;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h18;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h1C;

  localparam int CMD_RST   = 7;
  localparam int CMD_START = 6;
  localparam int CMD_RW    = 5;
  localparam logic [7:0] CMD_MASK = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RXWAIT = 2'd3
  } apb_state_e;

  typedef enum logic [3:0] {
    REG_TX,
    REG_RX,
    REG_STATUS,
    REG_SADDR,
    REG_CMD,
    REG_PRESCALE,
    REG_IRQ_STAT,
    REG_IRQ_EN,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [7:0] addr);
    case (addr)
      ADDR_TX:       return REG_TX;
      ADDR_RX:       return REG_RX;
      ADDR_STATUS:   return REG_STATUS;
      ADDR_SADDR:    return REG_SADDR;
      ADDR_CMD:      return REG_CMD;
      ADDR_PRESCALE: return REG_PRESCALE;
      ADDR_IRQ_STAT: return REG_IRQ_STAT;
      ADDR_IRQ_EN:   return REG_IRQ_EN;
      default:       return REG_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_irq_ctrl.sv
`default_nettype none
// i2c_irq_ctrl: interrupt status (set / write-1-to-clear), enable mask and
// registered interrupt output (rev 1.0).
module i2c_irq_ctrl #(
  parameter int N_IRQ = 4
) (
  input  logic             pclk_i,
  input  logic             preset_ni,
  input  logic [N_IRQ-1:0] event_i,
  input  logic [N_IRQ-1:0] clr_i,
  input  logic             en_we_i,
  input  logic [N_IRQ-1:0] en_wdata_i,
  output logic [N_IRQ-1:0] stat_o,
  output logic [N_IRQ-1:0] en_o,
  output logic             irq_o
);

  logic [N_IRQ-1:0] stat_q, stat_d;
  logic [N_IRQ-1:0] en_q, en_d;
  logic             irq_q, irq_d;

  always_comb begin
    // A new event wins over a clear of the same bit in the same cycle.
    stat_d = (stat_q & ~clr_i) | event_i;
    en_d   = en_we_i ? en_wdata_i : en_q;
    irq_d  = |(stat_q & en_q);
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      stat_q <= '0;
      en_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      en_q   <= en_d;
      irq_q  <= irq_d;
    end
  end

  assign stat_o = stat_q;
  assign en_o   = en_q;
  assign irq_o  = irq_q;

endmodule
`default_nettype wire

// File: rtl/apb_i2c_regfile.sv
`default_nettype none
// apb_i2c_regfile: APB3 register file and host interface between the bus and
// the I2C core / TX and RX FIFOs (rev 1.0).
module apb_i2c_regfile
  import i2c_regmap_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int FIFO_RD_LAT = 1,
  parameter int N_IRQ       = 4
) (
  input  logic                    pclk_i,
  input  logic                    preset_ni,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  input  logic                    tx_full_i,
  output logic                    tx_push_o,
  output logic [7:0]              tx_data_o,
  input  logic                    rx_empty_i,
  output logic                    rx_pop_o,
  input  logic [7:0]              rx_data_i,
  input  logic [7:0]              status_i,
  input  logic                    start_done_i,
  input  logic                    reset_done_i,
  input  logic [N_IRQ-1:0]        event_i,
  output logic [7:0]              reg_slave_address_o,
  output logic [7:0]              reg_command_o,
  output logic [7:0]              reg_prescale_o,
  output logic                    irq_o
);

  apb_state_e state_q, state_d, phase;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_push_q, tx_push_d;
  logic [7:0] saddr_q, saddr_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] prescale_q, prescale_d;

  reg_sel_e         sel;
  logic             access_now;
  logic             wr_en;
  logic             wr_err;
  logic [7:0]       rd_byte;
  logic [7:0]       rdata;
  logic             pready;
  logic             pslverr;
  logic             rx_pop;
  logic [N_IRQ-1:0] irq_stat;
  logic [N_IRQ-1:0] irq_en;
  logic [N_IRQ-1:0] irq_clr;
  logic             irq_en_we;
  logic             unused_bits;

  // The setup phase is recognised straight off the bus so that the following
  // cycle can be a zero-wait access.
  always_comb begin
    phase = state_q;
    if (state_q == ST_IDLE && psel_i && !penable_i) phase = ST_SETUP;
  end

  always_comb begin
    sel        = ((paddr_i >> 8) == '0) ? decode_addr(paddr_i[7:0]) : REG_NONE;
    access_now = (phase == ST_ACCESS) && psel_i && penable_i;
    wr_en      = access_now && pwrite_i && pstrb_i[0];
    irq_clr    = (wr_en && sel == REG_IRQ_STAT) ? pwdata_i[N_IRQ-1:0] : '0;
    irq_en_we  = wr_en && sel == REG_IRQ_EN;
  end

  always_comb begin
    case (sel)
      REG_NONE:           wr_err = 1'b1;
      REG_STATUS, REG_RX: wr_err = pstrb_i[0];
      REG_TX:             wr_err = pstrb_i[0] && tx_full_i;
      default:            wr_err = 1'b0;
    endcase
  end

  always_comb begin
    case (sel)
      REG_TX:       rd_byte = tx_data_q;
      REG_STATUS:   rd_byte = status_i;
      REG_SADDR:    rd_byte = saddr_q;
      REG_CMD:      rd_byte = cmd_q;
      REG_PRESCALE: rd_byte = prescale_q;
      REG_IRQ_STAT: rd_byte = 8'(irq_stat);
      REG_IRQ_EN:   rd_byte = 8'(irq_en);
      default:      rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_push_d  = 1'b0;
    saddr_d    = saddr_q;
    prescale_d = prescale_q;
    cmd_d      = cmd_q;
    pready     = 1'b0;
    pslverr    = 1'b0;
    rdata      = 8'h00;
    rx_pop     = 1'b0;

    if (reset_done_i) cmd_d[CMD_RST]   = 1'b1;
    if (start_done_i) cmd_d[CMD_START] = 1'b0;

    unique case (phase)
      ST_IDLE: ;
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (access_now) begin
          if (!pwrite_i && sel == REG_RX) begin
            if (rx_empty_i) begin
              pready  = 1'b1;
              pslverr = 1'b1;
            end else begin
              rx_pop = 1'b1;
              if (FIFO_RD_LAT == 0) begin
                pready = 1'b1;
                rdata  = rx_data_i;
              end else begin
                state_d = ST_RXWAIT;
                cnt_d   = 2'd1;
              end
            end
          end else if (pwrite_i) begin
            pready  = 1'b1;
            pslverr = wr_err;
            // A software write overrides any hardware CMD update this cycle.
            if (pstrb_i[0]) begin
              case (sel)
                REG_TX: begin
                  if (!tx_full_i) begin
                    tx_data_d = pwdata_i[7:0];
                    tx_push_d = 1'b1;
                  end
                end
                REG_SADDR:    saddr_d    = pwdata_i[7:0];
                REG_CMD:      cmd_d      = pwdata_i[7:0] & CMD_MASK;
                REG_PRESCALE: prescale_d = pwdata_i[7:0];
                default: ;
              endcase
            end
          end else begin
            pready  = 1'b1;
            pslverr = (sel == REG_NONE);
            rdata   = rd_byte;
          end
        end
      end
      ST_RXWAIT: begin
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 2'(FIFO_RD_LAT)) begin
          pready  = 1'b1;
          rdata   = rx_data_i;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      tx_data_q  <= 8'h00;
      tx_push_q  <= 1'b0;
      saddr_q    <= 8'h00;
      cmd_q      <= 8'h00;
      prescale_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_push_q  <= tx_push_d;
      saddr_q    <= saddr_d;
      cmd_q      <= cmd_d;
      prescale_q <= prescale_d;
    end
  end

  i2c_irq_ctrl #(
    .N_IRQ(N_IRQ)
  ) u_irq (
    .pclk_i    (pclk_i),
    .preset_ni (preset_ni),
    .event_i   (event_i),
    .clr_i     (irq_clr),
    .en_we_i   (irq_en_we),
    .en_wdata_i(pwdata_i[N_IRQ-1:0]),
    .stat_o    (irq_stat),
    .en_o      (irq_en),
    .irq_o     (irq_o)
  );

  assign unused_bits         = ^{pwdata_i, pstrb_i};
  assign prdata_o            = DATA_WIDTH'(rdata);
  assign pready_o            = pready;
  assign pslverr_o           = pslverr;
  assign rx_pop_o            = rx_pop;
  assign tx_push_o           = tx_push_q;
  assign tx_data_o           = tx_data_q;
  assign reg_slave_address_o = saddr_q;
  assign reg_command_o       = cmd_q;
  assign reg_prescale_o      = prescale_q;

endmodule
`default_nettype wire
